// File: rtl/mem_responder.sv
// Word-addressed memory responder: latches one Read/Write request, waits a
// programmable number of cycles, completes it and holds Done until the
// requesting strobe drops. A side preload port fills the array while idle.
module mem_responder #(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [31:0]       MAR,
   input  logic              Read,
   input  logic              Write,
   input  logic [DATA_W-1:0] BusMuxOut,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] Mdatain,
   output logic              Done,
   output logic              busy,
   output logic              err
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t              state, state_nxt;
   logic [3:0]          cnt;
   logic                op_read;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W-1:0]   mem [2**ADDR_W];

   logic accept, conflict, done_entry, strobe_held;

   // Preload has priority over the bus; only a single strobe is a request.
   assign accept     = (state == S_IDLE) && !ld_en && (Read ^ Write);
   assign conflict   = (state == S_IDLE) && !ld_en && Read && Write;
   // The counter is loaded with WAIT_CYCLES at acceptance and counts down to
   // zero; completion happens on the edge that sees zero, which puts Done at
   // edge WAIT_CYCLES+1 counting acceptance as edge 0 (also for zero waits).
   assign done_entry  = (state == S_WAIT) && (cnt == 4'd0);
   assign strobe_held = op_read ? Read : Write;

   // State register
   always_ff @(posedge clk) begin
      if (clr) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept)       state_nxt = S_WAIT;
         S_WAIT:  if (cnt == 4'd0)  state_nxt = S_DONE;
         S_DONE:  if (!strobe_held) state_nxt = S_IDLE;
         default:                   state_nxt = S_IDLE;
      endcase
   end

   // Status outputs decoded from the registered state
   always_comb begin
      Done = 1'b0;
      busy = 1'b0;
      if (state == S_DONE) Done = 1'b1;
      if (state != S_IDLE) busy = 1'b1;
   end

   // Request latch, wait counter, read data and error pulse
   always_ff @(posedge clk) begin
      if (clr) begin
         cnt     <= 4'd0;
         op_read <= 1'b0;
         addr    <= '0;
         wdata   <= '0;
         Mdatain <= '0;
         err     <= 1'b0;
      end else begin
         err <= conflict;
         if (accept) begin
            op_read <= Read;
            addr    <= MAR[ADDR_W-1:0];
            wdata   <= BusMuxOut;
            cnt     <= WAIT_INIT;
         end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (done_entry && op_read) Mdatain <= mem[addr];
      end
   end

   // Memory array: no reset; clr blocks commits so an aborted write is lost
   always_ff @(posedge clk) begin
      if (!clr) begin
         if (state == S_IDLE && ld_en)        mem[ld_addr] <= ld_data;
         else if (done_entry && !op_read)     mem[addr]    <= wdata;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (ADDR_W=9, DATA_W=32, WAIT_CYCLES=2).
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] MAR;
   logic        Read, Write;
   logic [31:0] BusMuxOut;
   logic        ld_en;
   logic [8:0]  ld_addr;
   logic [31:0] ld_data;
   logic [31:0] Mdatain;
   logic        Done, busy, err;

   int n_asserts = 0;
   int n_fail    = 0;

   mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(2)) dut (
      .clk(clk), .clr(clr), .MAR(MAR), .Read(Read), .Write(Write),
      .BusMuxOut(BusMuxOut), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .Mdatain(Mdatain), .Done(Done), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [8:0] a, input logic [31:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask

   // Full read transaction with latency checks at every edge.
   task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
      MAR = a; Read = 1'b1;
      tick();                                   // edge 0: accepted
      chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
      chk({tag, "_done0"}, {31'd0, Done}, 32'd0);
      MAR = 32'h0;                              // latched, must not matter
      tick();
      chk({tag, "_done1"}, {31'd0, Done}, 32'd0);
      tick();
      chk({tag, "_done2"}, {31'd0, Done}, 32'd0);
      tick();                                   // edge 3: complete
      chk({tag, "_done3"}, {31'd0, Done}, 32'd1);
      chk({tag, "_data"}, Mdatain, exp);
      tick();                                   // Done held while Read high
      chk({tag, "_hold"}, {31'd0, Done}, 32'd1);
      Read = 1'b0;
      tick();
      chk({tag, "_drop"}, {31'd0, Done}, 32'd0);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   // Full write transaction; data bus changes after acceptance and Mdatain
   // must keep the last read value throughout.
   task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] keep);
      MAR = a; BusMuxOut = d; Write = 1'b1;
      tick();
      chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
      BusMuxOut = 32'h0;
      tick();
      chk({tag, "_md1"}, Mdatain, keep);
      tick();
      chk({tag, "_done2"}, {31'd0, Done}, 32'd0);
      tick();
      chk({tag, "_done3"}, {31'd0, Done}, 32'd1);
      chk({tag, "_md3"}, Mdatain, keep);
      Write = 1'b0;
      tick();
      chk({tag, "_drop"}, {31'd0, Done}, 32'd0);
      chk({tag, "_md4"}, Mdatain, keep);
   endtask

   initial begin
      clr = 1'b1; MAR = '0; Read = 1'b0; Write = 1'b0; BusMuxOut = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      tick();
      clr = 1'b0;

      // Reset sanity: array survives clr, registers clear
      preload(9'd3, 32'hDEAD_BEEF);
      preload(9'd1, 32'h0000_000E);
      preload(9'd7, 32'hAAAA_5555);
      preload(9'd5, 32'h0505_0505);
      do_read("pre_rst", 32'd1, 32'h0000_000E);   // make Mdatain nonzero
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("rst_mdat", Mdatain, 32'h0);
      chk("rst_done", {31'd0, Done}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err",  {31'd0, err},  32'd0);
      do_read("rd3", 32'd3, 32'hDEAD_BEEF);

      // Read latency
      do_read("rd1", 32'd1, 32'h0000_000E);

      // Write then read; Mdatain keeps 0xE across the write
      do_write("wr4", 32'd4, 32'h0000_000F, 32'h0000_000E);
      do_read("rd4", 32'd4, 32'h0000_000F);

      // Conflict: both strobes -> err pulse, no acceptance, no write
      MAR = 32'd4; BusMuxOut = 32'h5A5A_5A5A; Read = 1'b1; Write = 1'b1;
      tick();
      chk("cf_err",  {31'd0, err},  32'd1);
      chk("cf_busy", {31'd0, busy}, 32'd0);
      Read = 1'b0; Write = 1'b0;
      tick();
      chk("cf_err_off", {31'd0, err}, 32'd0);
      chk("cf_busy2", {31'd0, busy}, 32'd0);
      do_read("cf_rd4", 32'd4, 32'h0000_000F);

      // Preload with Read: preload wins this cycle, read accepted next cycle
      ld_en = 1'b1; ld_addr = 9'd9; ld_data = 32'h0000_0099;
      MAR = 32'd9; Read = 1'b1;
      tick();
      chk("ld_busy", {31'd0, busy}, 32'd0);
      ld_en = 1'b0;
      do_read("ld_rd9", 32'd9, 32'h0000_0099);

      // Abort a write with clr during WAIT
      MAR = 32'd7; BusMuxOut = 32'h1234_5678; Write = 1'b1;
      tick();
      chk("ab_busy", {31'd0, busy}, 32'd1);
      tick();
      clr = 1'b1; Write = 1'b0;
      tick();
      clr = 1'b0;
      chk("ab_busy2", {31'd0, busy}, 32'd0);
      chk("ab_done",  {31'd0, Done}, 32'd0);

      // Address wrap; also proves mem[7] kept its old value
      do_read("wrap7", 32'hFFFF_FE07, 32'hAAAA_5555);
      do_read("wrap5", 32'h0000_0205, 32'h0505_0505);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
